stage_ctrl_dispatch: RTL and testbench
======================================

Name: stage_ctrl_dispatch

Overview:
- Per-stage control-channel endpoint for the RMT pipeline, parametrised by stage id and table geometry.
- Accepts AXI-Stream control packets on a daisy chain.
- Packets addressed to STAGE are consumed and decoded into write strobes for that stage's key-extract offset RAM, lookup CAM and action RAM; all other packets are forwarded to the next stage unchanged.

Parameters:
- STAGE, 0, stage id matched against header byte.
- C_DATA_WIDTH, 512, control AXIS data width.
- KEY_LEN, 197, lookup key width; CAM entry = key + mask, 2*KEY_LEN <= C_DATA_WIDTH.
- KEY_OFF, 18, key-extract offset entry width.
- ACT_LEN, 25, single action width.
- ACT_NUM, 25, actions per action-RAM entry; entry width AW = ACT_LEN*ACT_NUM.
- ADDR_WIDTH, 4, address width of all three tables.

Ports:
- axis_clk  in  1  clock.
- areset  in  1  asynchronous reset, active high.
- s_axis_tdata  in  C_DATA_WIDTH  control data in.
- s_axis_tvalid  in  1  control valid in.
- s_axis_tlast  in  1  control last in.
- s_axis_tready  out  1  control ready out.
- m_axis_tdata  out  C_DATA_WIDTH  forwarded data.
- m_axis_tvalid  out  1  forwarded valid.
- m_axis_tlast  out  1  forwarded last.
- m_axis_tready  in  1  downstream ready.
- key_off_entry_out  out  KEY_OFF  offset RAM write data.
- key_off_entry_out_valid  out  1  offset RAM write enable.
- key_off_entry_addr  out  ADDR_WIDTH  offset RAM write address.
- lookup_din  out  KEY_LEN  CAM key.
- lookup_din_mask  out  KEY_LEN  CAM mask.
- lookup_din_addr  out  ADDR_WIDTH  CAM address.
- lookup_din_en  out  1  CAM write enable.
- action_data_out  out  AW  action RAM data.
- action_en  out  1  action RAM write enable.
- action_addr  out  ADDR_WIDTH  action RAM address.

Behaviour:
- Header beat (first beat of packet) fields:
  - [7:0] stage id.
  - [11:8] resource: 0 offset, 1 CAM, 2 action, other = invalid.
  - [11+ADDR_WIDTH:12] start address.
  - [31:24] entry count N.
- Body layout:
  - Offset: one beat per entry, data in [KEY_OFF-1:0].
  - CAM: one beat per entry, key in [KEY_LEN-1:0], mask in [2*KEY_LEN-1:KEY_LEN].
  - Action: ACT_BEATS = ceil(AW/C_DATA_WIDTH) beats per entry, low part first, concatenated.
- FSM states: IDLE, FWD, WRITE, DROP.
- IDLE: header inspected combinationally.
  - Id != STAGE: forward beat, go to FWD unless tlast.
  - Id == STAGE, valid resource, N > 0: consume, latch resource/address/count, go to WRITE unless tlast.
  - Id matches but resource invalid or N = 0: consume, go to DROP unless tlast.
- FWD: m_axis_* = s_axis_* combinationally, s_axis_tready = m_axis_tready. Return to IDLE on handshake with tlast.
- WRITE: s_axis_tready = 1.
  - Each completed entry produces exactly one 1-cycle write strobe, registered, on the cycle after its final beat is accepted.
  - Address increments per entry; the first entry uses the start address.
  - Address wraps modulo 2^ADDR_WIDTH.
  - After N entries: if that beat has tlast, go to IDLE; otherwise go to DROP.
  - tlast before N entries complete: go to IDLE; a partial action entry is discarded, with no strobe.
- DROP: s_axis_tready = 1, nothing emitted; go to IDLE on tlast.
- m_axis_tvalid = 0 in all states except FWD, and in IDLE when forwarding.
- At most one write strobe is high per cycle. Data and address outputs hold their last values between strobes.
- Reset: all outputs 0 and state IDLE.
- Reset asserted mid-packet: state goes to IDLE. Remaining beats after reset are treated as a new header (upstream is reset together with this block).

Optional Feature:
- Macro STAGE_CTRL_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [15:0], reset 0.
  - Increments by 1 for each consumed packet that enters DROP from IDLE (invalid resource or N = 0), is truncated (tlast before N entries), or is overlong (WRITE to DROP).
  - Saturates at 16'hFFFF.
- When undefined: port absent, no counter logic.

Test Plan:
- STAGE=0, header {id 0, res 0, addr 3, N 2}, 3 beats, offsets 18'h00155 and 18'h002AA.
  - Expect key_off_entry_out_valid pulses at addr 3 then 4 with those values.
  - Expect m_axis_tvalid to stay 0.
- Header id 2 with 4 beats, m_axis_tready toggled 1,0,1,1.
  - Expect all 4 beats out identical and in order, tlast on the 4th, no write strobes.
- CAM write, addr 15, N 2.
  - Expect lookup_din_en at addr 15 then addr 0 (wrap).
  - Expect lookup_din_mask to equal the upper key-width field of each body beat.
- Action write, N 1, 2 beats.
  - Expect action_en exactly 1 cycle after the second beat.
  - Expect action_data_out = {beat2, beat1}[AW-1:0].
- Header res 0, N 3, tlast on the 2nd body beat.
  - Expect 2 strobes, FSM returns to IDLE.
  - Expect err_cnt = 1 with STAGE_CTRL_ERR_CNT_EN.
  - Expect the next header to be processed normally.
- Assert areset during a WRITE packet.
  - Expect all strobes 0 and s_axis_tready = 0 while reset is held.
  - Expect the first beat after release to be decoded as a header.

Source files
------------

// File: rtl/stage_ctrl_dispatch.sv
// Per-stage control-channel endpoint: consumes packets addressed to STAGE and emits table write strobes,
// forwards all others. Optional error counter enabled by define STAGE_CTRL_ERR_CNT_EN.
module stage_ctrl_dispatch #(
  parameter int STAGE        = 0,
  parameter int C_DATA_WIDTH = 512,
  parameter int KEY_LEN      = 197,
  parameter int KEY_OFF      = 18,
  parameter int ACT_LEN      = 25,
  parameter int ACT_NUM      = 25,
  parameter int ADDR_WIDTH   = 4,
  localparam int AW          = ACT_LEN*ACT_NUM
) (
  input  logic                    axis_clk,
  input  logic                    areset,
`ifdef STAGE_CTRL_ERR_CNT_EN
  output logic [15:0]             err_cnt,
`endif
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [KEY_OFF-1:0]      key_off_entry_out,
  output logic                    key_off_entry_out_valid,
  output logic [ADDR_WIDTH-1:0]   key_off_entry_addr,
  output logic [KEY_LEN-1:0]      lookup_din,
  output logic [KEY_LEN-1:0]      lookup_din_mask,
  output logic [ADDR_WIDTH-1:0]   lookup_din_addr,
  output logic                    lookup_din_en,
  output logic [AW-1:0]           action_data_out,
  output logic                    action_en,
  output logic [ADDR_WIDTH-1:0]   action_addr
);
  localparam int ACT_BEATS = (AW + C_DATA_WIDTH - 1) / C_DATA_WIDTH;
  localparam int BCW       = (ACT_BEATS > 1) ? $clog2(ACT_BEATS) : 1;
  localparam int ABW       = ACT_BEATS * C_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, FWD, WRITE, DROP} state_t;
  state_t state, nxt;

  logic [1:0]            res_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            cnt_q;
  logic [BCW-1:0]        beat_idx;
  logic [ABW-1:0]        act_buf, act_cat;
  logic                  hit, hdr_good, fwd, fire, entry_done, last_entry;

  assign hit        = s_axis_tdata[7:0] == 8'(STAGE);
  assign hdr_good   = hit && (s_axis_tdata[11:8] < 4'd3) && (s_axis_tdata[31:24] != 8'd0);
  assign fire       = s_axis_tvalid && s_axis_tready;
  assign entry_done = (res_q != 2'd2) || (beat_idx == BCW'(ACT_BEATS-1));
  assign last_entry = entry_done && (cnt_q == 8'd1);

  // final action beat goes straight from the bus into the top slice
  always_comb begin
    act_cat = act_buf;
    act_cat[(ACT_BEATS-1)*C_DATA_WIDTH +: C_DATA_WIDTH] = s_axis_tdata;
  end

  always_ff @(posedge axis_clk or posedge areset)
    if (areset) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (fire) begin
               if (s_axis_tlast) nxt = IDLE;
               else if (!hit)    nxt = FWD;
               else if (hdr_good) nxt = WRITE;
               else              nxt = DROP;
             end
      FWD:   if (fire && s_axis_tlast) nxt = IDLE;
      WRITE: if (fire) begin
               if (s_axis_tlast)    nxt = IDLE;
               else if (last_entry) nxt = DROP;
             end
      DROP:  if (fire && s_axis_tlast) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    fwd           = !areset && (state == FWD || (state == IDLE && !hit));
    s_axis_tready = !areset && (fwd ? m_axis_tready : 1'b1);
    m_axis_tvalid = fwd && s_axis_tvalid;
    m_axis_tlast  = fwd && s_axis_tlast;
    m_axis_tdata  = fwd ? s_axis_tdata : '0;
  end

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      res_q <= '0; addr_q <= '0; cnt_q <= '0; beat_idx <= '0; act_buf <= '0;
      key_off_entry_out <= '0; key_off_entry_out_valid <= 1'b0; key_off_entry_addr <= '0;
      lookup_din <= '0; lookup_din_mask <= '0; lookup_din_addr <= '0; lookup_din_en <= 1'b0;
      action_data_out <= '0; action_en <= 1'b0; action_addr <= '0;
    end else begin
      key_off_entry_out_valid <= 1'b0;
      lookup_din_en           <= 1'b0;
      action_en               <= 1'b0;
      if (fire && state == IDLE && hdr_good) begin
        res_q    <= s_axis_tdata[9:8];
        addr_q   <= s_axis_tdata[11+ADDR_WIDTH:12];
        cnt_q    <= s_axis_tdata[31:24];
        beat_idx <= '0;
      end
      if (fire && state == WRITE) begin
        if (!entry_done) begin
          act_buf[beat_idx*C_DATA_WIDTH +: C_DATA_WIDTH] <= s_axis_tdata;
          beat_idx <= beat_idx + 1'b1;
        end else begin
          beat_idx <= '0;
          addr_q   <= addr_q + 1'b1;
          cnt_q    <= cnt_q - 8'd1;
          case (res_q)
            2'd0: begin
              key_off_entry_out       <= s_axis_tdata[KEY_OFF-1:0];
              key_off_entry_addr      <= addr_q;
              key_off_entry_out_valid <= 1'b1;
            end
            2'd1: begin
              lookup_din      <= s_axis_tdata[KEY_LEN-1:0];
              lookup_din_mask <= s_axis_tdata[2*KEY_LEN-1:KEY_LEN];
              lookup_din_addr <= addr_q;
              lookup_din_en   <= 1'b1;
            end
            default: begin
              action_data_out <= act_cat[AW-1:0];
              action_addr     <= addr_q;
              action_en       <= 1'b1;
            end
          endcase
        end
      end
    end
  end

`ifdef STAGE_CTRL_ERR_CNT_EN
  // rejected header, truncated body (tlast early) or overlong body (tlast late)
  logic err_inc;
  assign err_inc = fire && ((state == IDLE && hit && (!hdr_good || s_axis_tlast)) ||
                            (state == WRITE && (s_axis_tlast != last_entry)));

  always_ff @(posedge axis_clk or posedge areset)
    if (areset)                           err_cnt <= '0;
    else if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_stage_ctrl_dispatch.sv
// Directed, table-driven bench for stage_ctrl_dispatch with STAGE=0 and default geometry.
module tb_stage_ctrl_dispatch;
  localparam int DW = 512, KL = 197, KO = 18, AWD = 625, ADW = 4;

  logic            axis_clk = 1'b0, areset;
  logic [DW-1:0]   s_axis_tdata, m_axis_tdata;
  logic            s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [KO-1:0]   key_off_entry_out;
  logic            key_off_entry_out_valid, lookup_din_en, action_en;
  logic [ADW-1:0]  key_off_entry_addr, lookup_din_addr, action_addr;
  logic [KL-1:0]   lookup_din, lookup_din_mask;
  logic [AWD-1:0]  action_data_out;
  logic [15:0]     err_cnt;

  int checks = 0, errors = 0;

  stage_ctrl_dispatch dut (
    .axis_clk(axis_clk), .areset(areset),
`ifdef STAGE_CTRL_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .key_off_entry_out(key_off_entry_out), .key_off_entry_out_valid(key_off_entry_out_valid),
    .key_off_entry_addr(key_off_entry_addr), .lookup_din(lookup_din), .lookup_din_mask(lookup_din_mask),
    .lookup_din_addr(lookup_din_addr), .lookup_din_en(lookup_din_en), .action_data_out(action_data_out),
    .action_en(action_en), .action_addr(action_addr)
  );

  always #5 axis_clk = ~axis_clk;

  // kind: 0 none, 1 offset, 2 CAM, 3 action; aux holds the earlier action beat
  typedef struct {
    logic [DW-1:0]  data;
    logic           last;
    logic [1:0]     kind;
    logic [ADW-1:0] addr;
    logic           fwd;
    logic [DW-1:0]  aux;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [DW-1:0] hdr(input int id, input int res, input int addr, input int n);
    logic [DW-1:0] h = '0;
    h[7:0] = 8'(id); h[11:8] = 4'(res); h[15:12] = 4'(addr); h[31:24] = 8'(n);
    return h;
  endfunction

  function automatic vec_t mk(input logic [DW-1:0] d, input logic l, input logic [1:0] k,
                              input int a, input logic f, input logic [DW-1:0] x);
    vec_t v;
    v.data = d; v.last = l; v.kind = k; v.addr = 4'(a); v.fwd = f; v.aux = x;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // caller is at a negedge; returns at the negedge after the beat was accepted
  task automatic send(input logic [DW-1:0] d, input logic l,
                      output logic mv, output logic [DW-1:0] md, output logic ml);
    bit ok = 0;
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = l;
    mv = 1'b0; md = '0; ml = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      if (s_axis_tready) begin
        ok = 1; mv = m_axis_tvalid; md = m_axis_tdata; ml = m_axis_tlast;
      end else @(negedge axis_clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL handshake: s_axis_tready not seen within 40 cycles");
    end
    @(negedge axis_clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic check_strobes(input logic [1:0] kind, input logic [ADW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] x);
    logic [2:0]    exp_s;
    logic [1023:0] cat;
    exp_s = (kind == 2'd1) ? 3'b001 : (kind == 2'd2) ? 3'b010 : (kind == 2'd3) ? 3'b100 : 3'b000;
    chk("strobes{act,cam,off}", {action_en, lookup_din_en, key_off_entry_out_valid}, exp_s);
    case (kind)
      2'd1: begin
        chk("off_addr", key_off_entry_addr, a);
        chk("off_data", key_off_entry_out, d[KO-1:0]);
      end
      2'd2: begin
        chk("cam_addr", lookup_din_addr, a);
        chk("cam_key", lookup_din, d[KL-1:0]);
        chk("cam_mask", lookup_din_mask, d[2*KL-1:KL]);
      end
      2'd3: begin
        cat = {d, x};
        chk("act_addr", action_addr, a);
        chk("act_data", action_data_out, cat[AWD-1:0]);
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          mv, ml;
    logic [DW-1:0] md;
    logic [KL-1:0] k1, m1, k2, m2;
    logic [DW-1:0] a1, a2, fb[4];
    logic [3:0]    pat;

    areset = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    k1 = KL'({7{32'hA5A5_1234}}); m1 = KL'({7{32'h0F0F_F0F0}});
    k2 = KL'({7{32'h1357_9BDF}}); m2 = KL'({7{32'hFFFF_0001}});
    a1 = {16{32'hDEAD_0001}};     a2 = {16{32'h0BAD_F00D}};

    // offset write, start 3, two entries
    tbl.push_back(mk(hdr(0,0,3,2),      1'b0, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(DW'(18'h00155),    1'b0, 2'd1, 3, 1'b0, '0));
    tbl.push_back(mk(DW'(18'h002AA),    1'b1, 2'd1, 4, 1'b0, '0));
    // CAM write wrapping 15 -> 0
    tbl.push_back(mk(hdr(0,1,15,2),     1'b0, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(DW'({m1, k1}),     1'b0, 2'd2, 15, 1'b0, '0));
    tbl.push_back(mk(DW'({m2, k2}),     1'b1, 2'd2, 0, 1'b0, '0));
    // action write, one two-beat entry
    tbl.push_back(mk(hdr(0,2,5,1),      1'b0, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(a1,                1'b0, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(a2,                1'b1, 2'd3, 5, 1'b0, a1));
    // truncated: N=3 but tlast on second body beat, then a normal packet
    tbl.push_back(mk(hdr(0,0,7,3),      1'b0, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(DW'(18'h00011),    1'b0, 2'd1, 7, 1'b0, '0));
    tbl.push_back(mk(DW'(18'h3FF22),    1'b1, 2'd1, 8, 1'b0, '0));
    tbl.push_back(mk(hdr(0,0,9,1),      1'b0, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(DW'(18'h12345),    1'b1, 2'd1, 9, 1'b0, '0));
    // invalid resource, N=0, overlong
    tbl.push_back(mk(hdr(0,5,0,1),      1'b0, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(DW'(18'h00777),    1'b1, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(hdr(0,0,0,0),      1'b0, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(DW'(18'h00888),    1'b1, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(hdr(0,0,1,1),      1'b0, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(DW'(18'h00999),    1'b0, 2'd1, 1, 1'b0, '0));
    tbl.push_back(mk(DW'(18'h00AAA),    1'b0, 2'd0, 0, 1'b0, '0));
    tbl.push_back(mk(DW'(18'h00BBB),    1'b1, 2'd0, 0, 1'b0, '0));
    // single-beat packet for another stage
    tbl.push_back(mk(hdr(3,0,0,0) | DW'(64'hFACE_0000_0000_0000), 1'b1, 2'd0, 0, 1'b1, '0));

    repeat (2) @(negedge axis_clk);
    s_axis_tvalid = 1'b1;
    #1;
    chk("rst_s_tready", s_axis_tready, 1'b0);
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_strobes", {action_en, lookup_din_en, key_off_entry_out_valid}, 3'b000);
    chk("rst_data", {action_data_out, lookup_din, key_off_entry_out, action_addr}, '0);
`ifdef STAGE_CTRL_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt, 16'd0);
`endif
    s_axis_tvalid = 1'b0;
    @(negedge axis_clk);
    areset = 1'b0;
    @(negedge axis_clk);

    foreach (tbl[i]) begin
      send(tbl[i].data, tbl[i].last, mv, md, ml);
      chk($sformatf("vec%0d_m_tvalid", i), mv, tbl[i].fwd);
      if (tbl[i].fwd) begin
        chk($sformatf("vec%0d_m_tdata", i), md, tbl[i].data);
        chk($sformatf("vec%0d_m_tlast", i), ml, tbl[i].last);
      end
      check_strobes(tbl[i].kind, tbl[i].addr, tbl[i].data, tbl[i].aux);
    end
`ifdef STAGE_CTRL_ERR_CNT_EN
    chk("err_cnt_after_table", err_cnt, 16'd4);
`endif

    // forwarding with downstream backpressure 1,0,1,1
    fb[0] = hdr(2,1,4,3);
    for (int i = 1; i < 4; i++) fb[i] = {16{32'(32'hC0DE_0000 + i)}};
    pat = 4'b1101;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          m_axis_tready = pat[i];
          @(negedge axis_clk);
        end
        m_axis_tready = 1'b1;
      end
      begin
        for (int j = 0; j < 4; j++) begin
          send(fb[j], j == 3, mv, md, ml);
          chk($sformatf("fwd%0d_m_tvalid", j), mv, 1'b1);
          chk($sformatf("fwd%0d_m_tdata", j), md, fb[j]);
          chk($sformatf("fwd%0d_m_tlast", j), ml, j == 3);
          chk($sformatf("fwd%0d_strobes", j), {action_en, lookup_din_en, key_off_entry_out_valid}, 3'b000);
        end
      end
    join

    // reset in the middle of a WRITE packet
    send(hdr(0,0,2,4), 1'b0, mv, md, ml);
    check_strobes(2'd0, '0, '0, '0);
    send(DW'(18'h20001), 1'b0, mv, md, ml);
    check_strobes(2'd1, 4'd2, DW'(18'h20001), '0);
    areset = 1'b1;
    s_axis_tdata = DW'(18'h0DEAD); s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    #1;
    chk("midrst_s_tready", s_axis_tready, 1'b0);
    chk("midrst_strobes", {action_en, lookup_din_en, key_off_entry_out_valid}, 3'b000);
    @(negedge axis_clk);
    chk("midrst_s_tready_held", s_axis_tready, 1'b0);
    chk("midrst_strobes_held", {action_en, lookup_din_en, key_off_entry_out_valid}, 3'b000);
    chk("midrst_m_tvalid", m_axis_tvalid, 1'b0);
    s_axis_tvalid = 1'b0;
    areset = 1'b0;
    send(hdr(0,0,6,1), 1'b0, mv, md, ml);
    check_strobes(2'd0, '0, '0, '0);
    send(DW'(18'h00ABC), 1'b1, mv, md, ml);
    check_strobes(2'd1, 4'd6, DW'(18'h00ABC), '0);
    @(negedge axis_clk);
    chk("post_rst_idle_strobes", {action_en, lookup_din_en, key_off_entry_out_valid}, 3'b000);
    chk("hold_off_data", key_off_entry_out, 18'h00ABC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
